// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - sequencing controller for the iterative AES encryption round datapath
module aes_round_ctrl #(
  parameter int NROUNDS = 10,
  parameter int RW      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          dp_stall,
  output logic          dp_load,
  output logic          dp_round_en,
  output logic          dp_final,
  output logic [RW-1:0] round_idx,
  output logic [7:0]    rcon,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  // Only the three AES key sizes are meaningful; anything else must not build.
  if (!(NROUNDS == 10 || NROUNDS == 12 || NROUNDS == 14)) begin : g_bad_nrounds
    $error("aes_round_ctrl: NROUNDS must be 10, 12 or 14");
  end
  if ((1 << RW) <= NROUNDS) begin : g_bad_rw
    $error("aes_round_ctrl: RW too narrow to hold NROUNDS");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  localparam logic [RW-1:0] LAST = RW'(NROUNDS);

  state_e        state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [7:0]    rcon_q, rcon_d;

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // State, round counter and Rcon registers; reset parks the FSM in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
    end
  end

  // Next-state logic and combinational output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcon_d      = rcon_q;
    in_ready    = 1'b0;
    dp_load     = 1'b0;
    dp_round_en = 1'b0;
    dp_final    = 1'b0;
    round_idx   = '0;
    rcon        = 8'h00;
    out_valid   = 1'b0;
    busy        = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end

      S_LOAD: begin
        dp_load = !dp_stall;
        if (!dp_stall) begin
          state_d = S_ROUND;
          cnt_d   = RW'(1);
          rcon_d  = 8'h01;
        end
      end

      S_ROUND: begin
        round_idx   = cnt_q;
        rcon        = rcon_q;
        dp_round_en = !dp_stall;
        dp_final    = (cnt_q == LAST) && !dp_stall;
        if (!dp_stall) begin
          if (cnt_q < LAST) begin
            cnt_d  = cnt_q + RW'(1);
            rcon_d = xtime(rcon_q);
          end else begin
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // A waiting request can be taken in the same cycle the result drains.
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_d = S_LOAD;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - self-checking bench for aes_round_ctrl (NROUNDS 10 and 14)
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic dp_stall = 1'b0;
  logic out_ready = 1'b0;

  always #5 clk = ~clk;

  logic       ir0, ld0, re0, fi0, ov0, by0;
  logic [3:0] idx0;
  logic [7:0] rc0;
  logic       ir1, ld1, re1, fi1, ov1, by1;
  logic [3:0] idx1;
  logic [7:0] rc1;

  aes_round_ctrl #(.NROUNDS(10), .RW(4)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .dp_stall(dp_stall), .dp_load(ld0), .dp_round_en(re0), .dp_final(fi0),
    .round_idx(idx0), .rcon(rc0), .out_valid(ov0), .out_ready(out_ready), .busy(by0)
  );

  aes_round_ctrl #(.NROUNDS(14), .RW(4)) u_dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .dp_stall(dp_stall), .dp_load(ld1), .dp_round_en(re1), .dp_final(fi1),
    .round_idx(idx1), .rcon(rc1), .out_valid(ov1), .out_ready(out_ready), .busy(by1)
  );

  typedef struct packed {
    logic       ir;
    logic       ld;
    logic       re;
    logic       fi;
    logic [3:0] idx;
    logic [7:0] rc;
    logic       ov;
    logic       by;
  } obs_t;

  obs_t obs [2];
  obs_t snap [2];
  assign obs[0] = {ir0, ld0, re0, fi0, idx0, rc0, ov0, by0};
  assign obs[1] = {ir1, ld1, re1, fi1, idx1, rc1, ov1, by1};

  int errors = 0;
  int checks = 0;

  // Reference model: position in the block schedule per instance.
  // -1 idle, 0 load, 1..N rounds, N+1 holding the result.
  int p [2];
  int nr [2] = '{10, 14};
  logic [7:0] rcon_tab [1:14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};

  task automatic chk(input string name, input int inst, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s inst=%0d t=%0t got=%0h exp=%0h", name, inst, $time, got, exp);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      int n;
      int q;
      logic in_rnd;
      n = nr[k];
      q = p[k];
      in_rnd = (q >= 1) && (q <= n);
      chk("m_in_ready", k, obs[k].ir, int'((q == -1) || ((q == n + 1) && out_ready)));
      chk("m_dp_load", k, obs[k].ld, int'((q == 0) && !dp_stall));
      chk("m_round_en", k, obs[k].re, int'(in_rnd && !dp_stall));
      chk("m_final", k, obs[k].fi, int'((q == n) && !dp_stall));
      chk("m_out_valid", k, obs[k].ov, int'(q == n + 1));
      chk("m_busy", k, obs[k].by, int'(q != -1));
      if (q <= n) begin
        chk("m_round_idx", k, obs[k].idx, in_rnd ? q : 0);
        chk("m_rcon", k, obs[k].rc, in_rnd ? int'(rcon_tab[q]) : 0);
      end
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (p[k] == -1) begin
        if (in_valid) p[k] = 0;
      end else if (p[k] <= nr[k]) begin
        if (!dp_stall) p[k] = p[k] + 1;
      end else if (out_ready) begin
        p[k] = in_valid ? 0 : -1;
      end
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance model at the rising edge.
  task automatic cycle(input logic iv, input logic st, input logic ordy);
    in_valid  = iv;
    dp_stall  = st;
    out_ready = ordy;
    @(negedge clk);
    check_model();
    snap[0] = obs[0];
    snap[1] = obs[1];
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((p[0] != -1 || p[1] != -1) && n < 60) begin
      cycle(1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("drain_timeout", 0, int'(n < 60), 1);
  endtask

  typedef struct {
    logic       iv, st, ordy;
    logic       ir, ld, re, fi;
    logic [3:0] idx;
    logic [7:0] rc;
    logic       ov;
    logic       chk_idx;
  } vec_t;

  vec_t vec [14];

  initial begin
    int lat, fc, frc, fidx;
    int done_q[$];

    // Single unstalled AES-128 block, cycle 0 is the accepting handshake.
    for (int c = 0; c < 14; c++) begin
      vec[c].iv      = (c == 0);
      vec[c].st      = 1'b0;
      vec[c].ordy    = 1'b1;
      vec[c].ir      = (c == 0) || (c == 12) || (c == 13);
      vec[c].ld      = (c == 1);
      vec[c].re      = (c >= 2) && (c <= 11);
      vec[c].fi      = (c == 11);
      vec[c].idx     = vec[c].re ? 4'(c - 1) : 4'd0;
      vec[c].rc      = vec[c].re ? rcon_tab[c - 1] : 8'h00;
      vec[c].ov      = (c == 12);
      vec[c].chk_idx = (c != 12);
    end

    p[0] = -1;
    p[1] = -1;
    @(posedge clk);
    #1;
    // Reset held across one edge, then released mid-cycle.
    cycle(1'b1, 1'b0, 1'b0);
    chk("rst_in_ready", 0, snap[0].ir, 1);
    chk("rst_dp_load", 0, snap[0].ld, 0);
    chk("rst_round_en", 0, snap[0].re, 0);
    chk("rst_out_valid", 0, snap[0].ov, 0);
    chk("rst_busy", 0, snap[0].by, 0);
    chk("rst_rcon", 0, snap[0].rc, 0);
    rst_n = 1'b1;

    for (int c = 0; c < 14; c++) begin
      cycle(vec[c].iv, vec[c].st, vec[c].ordy);
      chk("tbl_in_ready", c, snap[0].ir, vec[c].ir);
      chk("tbl_dp_load", c, snap[0].ld, vec[c].ld);
      chk("tbl_round_en", c, snap[0].re, vec[c].re);
      chk("tbl_final", c, snap[0].fi, vec[c].fi);
      chk("tbl_out_valid", c, snap[0].ov, vec[c].ov);
      if (vec[c].chk_idx) begin
        chk("tbl_round_idx", c, snap[0].idx, vec[c].idx);
        chk("tbl_rcon", c, snap[0].rc, vec[c].rc);
      end
    end
    drain();

    // Stall in LOAD and in round 5.
    lat = -1;
    cycle(1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      cycle(1'b0, (c == 1) || (c == 7), 1'b1);
      if (snap[0].ov && lat < 0) lat = c;
      if (c == 7 || c == 8) begin
        chk("stall_r5_idx", c, snap[0].idx, 5);
        chk("stall_r5_rcon", c, snap[0].rc, 8'h10);
        chk("stall_r5_en", c, snap[0].re, int'(c == 8));
      end
    end
    chk("stall_latency", 0, lat, 14);
    drain();

    // Consumer back-pressure for three cycles in HOLD.
    cycle(1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 11; c++) cycle(1'b0, 1'b0, 1'b1);
    for (int c = 12; c <= 14; c++) begin
      cycle(1'b0, 1'b0, 1'b0);
      chk("bp_out_valid", c, snap[0].ov, 1);
      chk("bp_in_ready", c, snap[0].ir, 0);
    end
    cycle(1'b0, 1'b0, 1'b1);
    chk("bp_hs_valid", 15, snap[0].ov, 1);
    chk("bp_hs_ready", 15, snap[0].ir, 1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("bp_after_valid", 16, snap[0].ov, 0);
    drain();

    // Back-to-back requests.
    for (int c = 0; c < 40; c++) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (snap[0].ov) done_q.push_back(c);
    end
    chk("b2b_count", 0, done_q.size(), 3);
    for (int i = 0; i < done_q.size() && i < 3; i++) chk("b2b_done_cycle", i, done_q[i], 12 * (i + 1));
    drain();

    // Asynchronous reset during round 6.
    cycle(1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 6; c++) cycle(1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    p[0] = -1;
    p[1] = -1;
    chk("arst_in_ready", 0, obs[0].ir, 1);
    chk("arst_round_en", 0, obs[0].re, 0);
    chk("arst_round_idx", 0, obs[0].idx, 0);
    chk("arst_busy", 0, obs[0].by, 0);
    chk("arst_busy14", 1, obs[1].by, 0);
    cycle(1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      cycle(1'b0, 1'b0, 1'b1);
      chk("arst_no_valid", c, snap[0].ov, 0);
    end
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("arst_new_load", 0, snap[0].ld, 1);
    chk("arst_new_idx0", 0, snap[0].idx, 0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("arst_new_r1_idx", 0, snap[0].idx, 1);
    chk("arst_new_r1_rcon", 0, snap[0].rc, 8'h01);
    drain();

    // AES-256 instance: final round position and Rcon.
    fc = -1;
    frc = -1;
    fidx = -1;
    cycle(1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 17; c++) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (snap[1].fi) begin
        fc = c;
        frc = snap[1].rc;
        fidx = snap[1].idx;
      end
    end
    chk("n14_final_cycle", 1, fc, 15);
    chk("n14_final_rcon", 1, frc, 8'h4d);
    chk("n14_final_idx", 1, fidx, 14);
    drain();

    // Randomized traffic against the model, with occasional async resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) begin
        rst_n = 1'b0;
        #1;
        p[0] = -1;
        p[1] = -1;
        cycle($urandom_range(1), $urandom_range(3) == 0, $urandom_range(9) < 6);
        rst_n = 1'b1;
      end else begin
        cycle($urandom_range(1), $urandom_range(3) == 0, $urandom_range(9) < 6);
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
